id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register of the 5-stage core with integrated load-use hazard detection and bubble insertion. It captures decoded operands and control from the ID stage and presents them as the `ex_*` signals. The EX-stage ALU and the forwarding unit consume these, including `ex_rs1`, `ex_rs2` and the rd/write-enable pair that becomes `me_rd`/`me_regs_write` one stage later. It stalls IF/ID for `LOAD_LAT` cycles when the instruction in ID reads the destination of a load in EX, because forwarding cannot cover that case.

## Interface
- `XLEN`, 32, datapath width
- `ALUOP_W`, 4, ALU operation code width
- `LOAD_LAT`, 1, bubbles inserted per load-use hazard (legal 1..7)
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `id_valid` in 1 — ID holds a real instruction
- `id_rs1`, `id_rs2`, `id_rd` in 5 each — register indices
- `id_rs1_data`, `id_rs2_data`, `id_imm`, `id_pc` in XLEN each
- `id_alu_op` in ALUOP_W; `id_alu_src` in 1
- `id_mem_read`, `id_mem_write`, `id_regs_write` in 1 each
- `flush_ex` in 1 — taken branch/jump resolved in EX; kill the ID instruction
- `stall_mem` in 1 — data memory not ready; freeze this register
- `ex_valid`, `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`, `ex_pc`, `ex_alu_op`, `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_regs_write` out — registered copies of the `id_*` fields
- `stall_if_id` out 1 — hold PC and IF/ID this cycle
- `bubble_cnt` out 16 — saturating count of load-use bubbles

## Operation
- `lu_hazard` = `ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
- FSM states (defined in `define.vh`):
  - RUN
  - STALL, with 3-bit counter `cnt`
- Per-edge priority, highest first:
  1. reset
  2. `stall_mem`: all registers, `state`, `cnt` and `bubble_cnt` hold
  3. `flush_ex`: load bubble, state ← RUN, `cnt` ← 0, no count
  4. load-use bubble: condition is RUN with `lu_hazard`, or STALL; load bubble and increment `bubble_cnt`
  5. otherwise: load the `id_*` fields
- Transitions:
  - RUN with `lu_hazard` and `LOAD_LAT` = 1: stay RUN.
  - RUN with `lu_hazard` and `LOAD_LAT` > 1: go to STALL with `cnt` ← `LOAD_LAT`−1.
  - STALL: `cnt` decrements; STALL → RUN when `cnt` == 1 at the edge.
  - Total bubbles per hazard = `LOAD_LAT`.
- Bubble contents: all `ex_*` outputs = 0. This includes `ex_valid`, `ex_rd`, `ex_rs1`, `ex_rs2`, the write enables, and all data fields.
- `stall_if_id` = `((state == RUN & lu_hazard) | state == STALL) & ~flush_ex`. Its value during `stall_mem` is don't-care.
- `bubble_cnt` saturates at 0xFFFF; it never wraps.

## Timing
- Reset: every output 0, state RUN, `cnt` 0, `bubble_cnt` 0. Reset may assert at any cycle, including mid-STALL; it aborts the stall immediately.
- Registered outputs: every `ex_*` output and `bubble_cnt`.
  - `ex_*` shows the `id_*` values one edge after capture.
  - `bubble_cnt` updates on the same edge that loads the bubble.
- `stall_if_id` is combinational from current state, the `ex_*` registers, the `id_*` inputs and `flush_ex`. It is asserted in the same cycle as the hazard.
- Load in EX at cycle N with a dependent instruction in ID, `LOAD_LAT` = 1:
  - `stall_if_id` = 1 in cycle N.
  - Bubble is in EX at N+1.
  - Dependent instruction enters EX at N+2. The load is then in WB and the forwarding unit's MEM/WB path supplies the operand.
- `flush_ex` together with `lu_hazard`: flush wins, and `stall_if_id` = 0.
- `flush_ex` in STALL: abort to RUN, one flush bubble, no further stall.
- `stall_mem` during STALL: `cnt` frozen; the bubble count resumes after release.
- A dependent instruction with rs = x0 never stalls. A load with rd = x0 never stalls.

## Structure
- `define.vh` holds:
  - `IDEX_RUN` / `IDEX_STALL` state encodings
  - ALU op width macro
  - `BUBBLE_CNT_W` (16)
- One sub-module, `load_use_detect`: pure combinational comparator producing `lu_hazard`.
- The register bank, FSM and counter are in `id_ex_stage`.

## Test plan
1. Normal flow: `id_rd`=5, `id_regs_write`=1, `id_valid`=1, no hazards → next cycle `ex_rd`=5, `ex_regs_write`=1, `ex_valid`=1, `stall_if_id`=0.
2. Load-use, `LOAD_LAT`=1: `ex_mem_read`=1, `ex_rd`=3, `id_rs2`=3 → `stall_if_id`=1 for exactly 1 cycle; next `ex_valid`=0, `ex_rd`=0; `bubble_cnt`=1; the dependent instruction reaches EX 2 cycles after detection.
3. `LOAD_LAT`=3, same hazard → `stall_if_id` high 3 cycles, 3 bubbles, `bubble_cnt`=3; `stall_mem` pulsed 2 cycles mid-stall → total stall 5 cycles, `bubble_cnt` still 3.
4. Hazard plus `flush_ex` in the same cycle → `stall_if_id`=0, bubble loaded, `bubble_cnt` unchanged, state RUN.
5. x0 cases: `ex_rd`=0 load with `id_rs1`=0 → no stall; `rst_n` low mid-STALL → all outputs 0 asynchronously, RUN after release.
6. Saturation: preload 0xFFFE bubbles via repeated hazards → `bubble_cnt` reaches 0xFFFF and holds on the next hazard.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: FSM encodings,
// default widths and the saturating bubble-counter helper.
package id_ex_stage_pkg;

  typedef enum logic {
    IDEX_RUN   = 1'b0,
    IDEX_STALL = 1'b1
  } idex_state_t;

  localparam int IDEX_ALUOP_W = 4;
  localparam int BUBBLE_CNT_W = 16;

  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use comparator: the instruction in ID reads the destination of a load
// that is still in EX, which forwarding cannot resolve in time.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       lu_hazard
);

  assign lu_hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall FSM, bubble insertion and a
// saturating count of inserted load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALUOP_W  = IDEX_ALUOP_W,
  parameter int LOAD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [4:0]              id_rs1,
  input  logic [4:0]              id_rs2,
  input  logic [4:0]              id_rd,
  input  logic [XLEN-1:0]         id_rs1_data,
  input  logic [XLEN-1:0]         id_rs2_data,
  input  logic [XLEN-1:0]         id_imm,
  input  logic [XLEN-1:0]         id_pc,
  input  logic [ALUOP_W-1:0]      id_alu_op,
  input  logic                    id_alu_src,
  input  logic                    id_mem_read,
  input  logic                    id_mem_write,
  input  logic                    id_regs_write,
  input  logic                    flush_ex,
  input  logic                    stall_mem,
  output logic                    ex_valid,
  output logic [4:0]              ex_rs1,
  output logic [4:0]              ex_rs2,
  output logic [4:0]              ex_rd,
  output logic [XLEN-1:0]         ex_rs1_data,
  output logic [XLEN-1:0]         ex_rs2_data,
  output logic [XLEN-1:0]         ex_imm,
  output logic [XLEN-1:0]         ex_pc,
  output logic [ALUOP_W-1:0]      ex_alu_op,
  output logic                    ex_alu_src,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write,
  output logic                    ex_regs_write,
  output logic                    stall_if_id,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

  // All ex_* fields travel as one bus so a bubble is simply all zeros.
  localparam int PW = 1 + 3 * 5 + 4 * XLEN + ALUOP_W + 4;

  logic [PW-1:0] id_bus;
  logic [PW-1:0] ex_bus;
  idex_state_t   state;
  logic [2:0]    cnt;
  logic          lu_hazard;
  logic          take_bubble;

  assign id_bus = {id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
                   id_imm, id_pc, id_alu_op, id_alu_src, id_mem_read,
                   id_mem_write, id_regs_write};

  assign {ex_valid, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
          ex_imm, ex_pc, ex_alu_op, ex_alu_src, ex_mem_read,
          ex_mem_write, ex_regs_write} = ex_bus;

  load_use_detect u_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .lu_hazard   (lu_hazard)
  );

  assign take_bubble = ((state == IDEX_RUN) & lu_hazard) | (state == IDEX_STALL);
  assign stall_if_id = take_bubble & ~flush_ex;

  // The first bubble comes from RUN; STALL supplies the remaining LOAD_LAT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_bus     <= '0;
      state      <= IDEX_RUN;
      cnt        <= 3'd0;
      bubble_cnt <= '0;
    end else if (stall_mem) begin
      ex_bus     <= ex_bus;
      state      <= state;
      cnt        <= cnt;
      bubble_cnt <= bubble_cnt;
    end else if (flush_ex) begin
      ex_bus <= '0;
      state  <= IDEX_RUN;
      cnt    <= 3'd0;
    end else if (take_bubble) begin
      ex_bus     <= '0;
      bubble_cnt <= sat_inc(bubble_cnt);
      if (state == IDEX_RUN) begin
        if (LOAD_LAT > 1) begin
          state <= IDEX_STALL;
          cnt   <= 3'(LOAD_LAT - 1);
        end
      end else if (cnt == 3'd1) begin
        state <= IDEX_RUN;
        cnt   <= 3'd0;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end else begin
      ex_bus <= id_bus;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: three instances (LOAD_LAT 1, 3, 7) share
// one stimulus stream; each step checks against hand-computed values.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_mem_read, id_mem_write, id_regs_write;
  logic        flush_ex, stall_mem;

  logic        a_valid, b_valid, c_valid;
  logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd, c_rs1, c_rs2, c_rd;
  logic [31:0] a_rs1_data, a_rs2_data, a_imm, a_pc;
  logic [31:0] b_rs1_data, b_rs2_data, b_imm, b_pc;
  logic [31:0] c_rs1_data, c_rs2_data, c_imm, c_pc;
  logic [3:0]  a_alu_op, b_alu_op, c_alu_op;
  logic        a_alu_src, a_mem_read, a_mem_write, a_regs_write, a_stall;
  logic        b_alu_src, b_mem_read, b_mem_write, b_regs_write, b_stall;
  logic        c_alu_src, c_mem_read, c_mem_write, c_regs_write, c_stall;
  logic [15:0] a_bubbles, b_bubbles, c_bubbles;

  int tests;
  int failed;
  int n;
  logic saw_stall;

  id_ex_stage #(.XLEN(32), .ALUOP_W(4), .LOAD_LAT(1)) dut_lat1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_pc(id_pc), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_regs_write(id_regs_write), .flush_ex(flush_ex),
    .stall_mem(stall_mem), .ex_valid(a_valid), .ex_rs1(a_rs1), .ex_rs2(a_rs2), .ex_rd(a_rd),
    .ex_rs1_data(a_rs1_data), .ex_rs2_data(a_rs2_data), .ex_imm(a_imm), .ex_pc(a_pc),
    .ex_alu_op(a_alu_op), .ex_alu_src(a_alu_src), .ex_mem_read(a_mem_read),
    .ex_mem_write(a_mem_write), .ex_regs_write(a_regs_write), .stall_if_id(a_stall),
    .bubble_cnt(a_bubbles)
  );

  id_ex_stage #(.XLEN(32), .ALUOP_W(4), .LOAD_LAT(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_pc(id_pc), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_regs_write(id_regs_write), .flush_ex(flush_ex),
    .stall_mem(stall_mem), .ex_valid(b_valid), .ex_rs1(b_rs1), .ex_rs2(b_rs2), .ex_rd(b_rd),
    .ex_rs1_data(b_rs1_data), .ex_rs2_data(b_rs2_data), .ex_imm(b_imm), .ex_pc(b_pc),
    .ex_alu_op(b_alu_op), .ex_alu_src(b_alu_src), .ex_mem_read(b_mem_read),
    .ex_mem_write(b_mem_write), .ex_regs_write(b_regs_write), .stall_if_id(b_stall),
    .bubble_cnt(b_bubbles)
  );

  id_ex_stage #(.XLEN(32), .ALUOP_W(4), .LOAD_LAT(7)) dut_lat7 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_pc(id_pc), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_regs_write(id_regs_write), .flush_ex(flush_ex),
    .stall_mem(stall_mem), .ex_valid(c_valid), .ex_rs1(c_rs1), .ex_rs2(c_rs2), .ex_rd(c_rd),
    .ex_rs1_data(c_rs1_data), .ex_rs2_data(c_rs2_data), .ex_imm(c_imm), .ex_pc(c_pc),
    .ex_alu_op(c_alu_op), .ex_alu_src(c_alu_src), .ex_mem_read(c_mem_read),
    .ex_mem_write(c_mem_write), .ex_regs_write(c_regs_write), .stall_if_id(c_stall),
    .bubble_cnt(c_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] op,
                               input logic src, input logic mr, input logic mw, input logic rw);
    id_valid      = v;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_rs1_data   = d1;
    id_rs2_data   = d2;
    id_imm        = imm;
    id_pc         = pc;
    id_alu_op     = op;
    id_alu_src    = src;
    id_mem_read   = mr;
    id_mem_write  = mw;
    id_regs_write = rw;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    saw_stall = 1'b0;
    rst_n = 1'b0;
    flush_ex = 1'b0;
    stall_mem = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("reset_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("reset_bubbles", {16'd0, a_bubbles}, 32'd0);
    checkOutput("reset_stall", {31'd0, a_stall}, 32'd0);
    rst_n = 1'b1;

    // Normal flow
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 32'hAAAA, 32'hBBBB, 32'h10, 32'h100, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("norm_stall", {31'd0, a_stall}, 32'd0);
    tick();
    checkOutput("norm_rd", {27'd0, a_rd}, 32'd5);
    checkOutput("norm_rw", {31'd0, a_regs_write}, 32'd1);
    checkOutput("norm_valid", {31'd0, a_valid}, 32'd1);
    checkOutput("norm_rs1_data", a_rs1_data, 32'hAAAA);
    checkOutput("norm_pc", a_pc, 32'h100);
    checkOutput("norm_alu_op", {28'd0, a_alu_op}, 32'd3);
    checkOutput("norm_lat3_rd", {27'd0, b_rd}, 32'd5);

    // Load-use: load x3, then dependent reading x3 through rs2
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd3, 32'h0, 32'h0, 32'h4, 32'h104, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 checkOutput("load_stall", {31'd0, a_stall}, 32'd0);
    tick();
    checkOutput("load_mr", {31'd0, a_mem_read}, 32'd1);
    applyStimulus(1'b1, 5'd4, 5'd3, 5'd6, 32'h44, 32'h33, 32'h0, 32'h108, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("lu1_stall", {31'd0, a_stall}, 32'd1);
    checkOutput("lu3_stall", {31'd0, b_stall}, 32'd1);
    tick();
    checkOutput("lu1_bub_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("lu1_bub_rd", {27'd0, a_rd}, 32'd0);
    checkOutput("lu1_bub_rs2", {27'd0, a_rs2}, 32'd0);
    checkOutput("lu1_bub_cnt", {16'd0, a_bubbles}, 32'd1);
    checkOutput("lu1_stall_end", {31'd0, a_stall}, 32'd0);
    checkOutput("lu3_stall_c2", {31'd0, b_stall}, 32'd1);
    checkOutput("lu3_bub_cnt1", {16'd0, b_bubbles}, 32'd1);
    tick();
    checkOutput("lu1_dep_rd", {27'd0, a_rd}, 32'd6);
    checkOutput("lu1_dep_rs2", {27'd0, a_rs2}, 32'd3);
    checkOutput("lu1_dep_valid", {31'd0, a_valid}, 32'd1);
    checkOutput("lu1_dep_rs2_data", a_rs2_data, 32'h33);
    checkOutput("lu3_bub_cnt2", {16'd0, b_bubbles}, 32'd2);
    checkOutput("lu3_bub_valid", {31'd0, b_valid}, 32'd0);
    checkOutput("lu3_stall_c3", {31'd0, b_stall}, 32'd1);

    // Memory stall freezes the STALL countdown and the bubble count
    stall_mem = 1'b1;
    tick();
    checkOutput("smem_cnt_a", {16'd0, b_bubbles}, 32'd2);
    checkOutput("smem_lat1_hold", {27'd0, a_rd}, 32'd6);
    tick();
    checkOutput("smem_cnt_b", {16'd0, b_bubbles}, 32'd2);
    checkOutput("smem_valid", {31'd0, b_valid}, 32'd0);
    stall_mem = 1'b0;
    #1 checkOutput("smem_resume_stall", {31'd0, b_stall}, 32'd1);
    tick();
    checkOutput("lu3_bub_cnt3", {16'd0, b_bubbles}, 32'd3);
    checkOutput("lu3_bub3_valid", {31'd0, b_valid}, 32'd0);
    checkOutput("lu3_stall_done", {31'd0, b_stall}, 32'd0);
    tick();
    checkOutput("lu3_dep_rd", {27'd0, b_rd}, 32'd6);
    checkOutput("lu3_dep_valid", {31'd0, b_valid}, 32'd1);

    // Hazard and flush in the same cycle: flush wins
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h8, 32'h200, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 checkOutput("fl_pre_stall", {31'd0, b_stall}, 32'd0);
    tick();
    applyStimulus(1'b1, 5'd7, 5'd2, 5'd9, 32'h77, 32'h22, 32'h0, 32'h204, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    flush_ex = 1'b1;
    #1 checkOutput("fl_lat1_stall", {31'd0, a_stall}, 32'd0);
    checkOutput("fl_lat3_stall", {31'd0, b_stall}, 32'd0);
    tick();
    checkOutput("fl_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("fl_lat1_cnt", {16'd0, a_bubbles}, 32'd1);
    checkOutput("fl_lat3_cnt", {16'd0, b_bubbles}, 32'd3);
    checkOutput("fl_lat3_rd", {27'd0, b_rd}, 32'd0);
    flush_ex = 1'b0;
    #1 checkOutput("fl_run_stall", {31'd0, b_stall}, 32'd0);
    tick();
    checkOutput("fl_dep_rd_lat3", {27'd0, b_rd}, 32'd9);
    checkOutput("fl_dep_rd_lat1", {27'd0, a_rd}, 32'd9);

    // Flush during STALL aborts the remaining bubbles
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 32'hC, 32'h300, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd2, 5'd8, 5'd10, 32'h22, 32'h88, 32'h0, 32'h304, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("fs_hazard_stall", {31'd0, b_stall}, 32'd1);
    tick();
    checkOutput("fs_lat3_cnt", {16'd0, b_bubbles}, 32'd4);
    checkOutput("fs_lat1_cnt", {16'd0, a_bubbles}, 32'd2);
    flush_ex = 1'b1;
    #1 checkOutput("fs_flush_stall", {31'd0, b_stall}, 32'd0);
    tick();
    checkOutput("fs_cnt_hold", {16'd0, b_bubbles}, 32'd4);
    checkOutput("fs_valid", {31'd0, b_valid}, 32'd0);
    flush_ex = 1'b0;
    #1 checkOutput("fs_run_stall", {31'd0, b_stall}, 32'd0);
    tick();
    checkOutput("fs_dep_rd", {27'd0, b_rd}, 32'd10);

    // x0: load to x0 with a consumer reading x0
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'h400, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 32'h404, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 checkOutput("x0_lat1_stall", {31'd0, a_stall}, 32'd0);
    checkOutput("x0_lat3_stall", {31'd0, b_stall}, 32'd0);
    tick();
    checkOutput("x0_rd", {27'd0, a_rd}, 32'd11);
    checkOutput("x0_cnt", {16'd0, a_bubbles}, 32'd2);

    // Asynchronous reset in the middle of a STALL
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 32'h500, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd12, 32'h3, 32'h0, 32'h0, 32'h504, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("rst_pre_stall", {31'd0, b_stall}, 32'd1);
    checkOutput("rst_pre_rd", {27'd0, a_rd}, 32'd12);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_rd", {27'd0, a_rd}, 32'd0);
    checkOutput("rst_async_valid", {31'd0, a_valid}, 32'd0);
    checkOutput("rst_async_pc", a_pc, 32'd0);
    checkOutput("rst_async_stall", {31'd0, b_stall}, 32'd0);
    checkOutput("rst_async_cnt3", {16'd0, b_bubbles}, 32'd0);
    checkOutput("rst_async_cnt1", {16'd0, a_bubbles}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1 checkOutput("rst_run_stall", {31'd0, b_stall}, 32'd0);
    tick();
    checkOutput("rst_run_rd", {27'd0, b_rd}, 32'd12);
    checkOutput("rst_run_valid", {31'd0, b_valid}, 32'd1);

    // Saturation: a load depending on its own rd re-triggers a hazard forever
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h600, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (c_bubbles != 16'hFFFF && n < 80000) begin
      tick();
      n++;
    end
    checkOutput("sat_reach", {16'd0, c_bubbles}, 32'h0000FFFF);
    for (int i = 0; i < 16; i++) begin
      tick();
      saw_stall = saw_stall | c_stall;
    end
    checkOutput("sat_hazards_seen", {31'd0, saw_stall}, 32'd1);
    checkOutput("sat_hold", {16'd0, c_bubbles}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
